// File: rtl/sysid_pkg.sv
// rtl/sysid_pkg.sv - shared types and constants for the SysID checker
package sysid_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RD_ID  = 2'd1,
      RD_TS  = 2'd2,
      FINISH = 2'd3
   } state_t;

   localparam logic ADDR_ID = 1'b0;
   localparam logic ADDR_TS = 1'b1;

   localparam int CTR_W = 16;

endpackage

// File: rtl/sysid_timeout_ctr.sv
// rtl/sysid_timeout_ctr.sv - per-read stall counter with limit compare
module sysid_timeout_ctr
   import sysid_pkg::*;
(
   input  logic             clock,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             inc,
   input  logic [CTR_W-1:0] limit,
   output logic             expired
);

   logic [CTR_W-1:0] count;

   // Count stall cycles; clear has priority and the count parks once the limit is hit.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && !expired) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (count == limit);

endmodule

// File: rtl/sysid_checker.sv
// rtl/sysid_checker.sv - reads SysID ID and timestamp words and checks them
module sysid_checker
   import sysid_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID    = 32'd0,
   parameter logic [31:0] EXPECTED_TS    = 32'd1614655942,
   parameter int unsigned TIMEOUT_CYCLES = 1023
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   localparam logic [CTR_W-1:0] LIMIT = TIMEOUT_CYCLES[CTR_W-1:0];

   state_t state;
   logic   reading;
   logic   ctr_clear;
   logic   ctr_inc;
   logic   expired;

   assign reading   = (state == RD_ID) || (state == RD_TS);
   // Clearing outside the read states and on ID completion gives a fresh count on entry to each read.
   assign ctr_clear = !reading || ((state == RD_ID) && !avm_waitrequest);
   assign ctr_inc   = reading && avm_waitrequest;

   sysid_timeout_ctr u_timeout_ctr (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (ctr_clear),
      .inc     (ctr_inc),
      .limit   (LIMIT),
      .expired (expired)
   );

   // Sequencer: all bus strobes and status flags are registered here.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         avm_address <= ADDR_ID;
         avm_read    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         id_ok       <= 1'b0;
         ts_ok       <= 1'b0;
         timeout     <= 1'b0;
         id_value    <= '0;
         ts_value    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state       <= RD_ID;
                  avm_address <= ADDR_ID;
                  avm_read    <= 1'b1;
                  busy        <= 1'b1;
                  id_ok       <= 1'b0;
                  ts_ok       <= 1'b0;
                  timeout     <= 1'b0;
                  id_value    <= '0;
                  ts_value    <= '0;
               end
            end
            RD_ID: begin
               if (!avm_waitrequest) begin
                  state       <= RD_TS;
                  id_value    <= avm_readdata;
                  avm_address <= ADDR_TS;
               end else if (expired) begin
                  // ID never arrived: the timestamp read is skipped and both flags stay 0.
                  state    <= FINISH;
                  avm_read <= 1'b0;
                  timeout  <= 1'b1;
                  done     <= 1'b1;
               end
            end
            RD_TS: begin
               if (!avm_waitrequest) begin
                  state    <= FINISH;
                  ts_value <= avm_readdata;
                  avm_read <= 1'b0;
                  id_ok    <= (id_value == EXPECTED_ID);
                  ts_ok    <= (avm_readdata == EXPECTED_TS);
                  done     <= 1'b1;
               end else if (expired) begin
                  state    <= FINISH;
                  avm_read <= 1'b0;
                  timeout  <= 1'b1;
                  id_ok    <= (id_value == EXPECTED_ID);
                  done     <= 1'b1;
               end
            end
            FINISH: begin
               state       <= IDLE;
               busy        <= 1'b0;
               avm_address <= ADDR_ID;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
